psx_packet_tx: RTL
==================

# psx_packet_tx

Serial packet transmitter for the PSX controller-state link, the sending end of the format the emulator board's serial receiver decodes. On a start strobe it reads a controller-state snapshot from a synchronous byte buffer and frames it as `0x5<port>`, flags, then N data bytes. It shifts the packet out as 8N1 UART on `SERIAL_TX`, then holds the line idle long enough for the receiver to resynchronise. It belongs on the host/bridge-side FPGA that forwards controller state to the emulator board.

## Interface
- `CLKS_PER_BIT`, 1250, FIFO_clk cycles per UART bit (48 MHz / 38400 baud).
- `IDLE_BITS`, 16, bit periods of forced idle (line high) after each packet's last stop bit.
- `FIFO_clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high; clock FIFO_clk.
- `start`  in  1  request one packet; sampled only while `busy`=0.
- `port_number`  in  4  slot address, captured on accepted `start`.
- `flags`  in  3  state flags, captured on accepted `start`; selects the data length.
- `rd_addr`  out  5  buffer read address (data byte index).
- `rd_data`  in  8  buffer read data, synchronous, 1-cycle latency after `rd_addr`.
- `busy`  out  1  packet in progress, including the idle gap.
- `done`  out  1  one-cycle pulse when the packet and gap are complete.
- `SERIAL_TX`  out  1  UART line, idle high.

## Operation
- Reset values: `SERIAL_TX`=1, `busy`=0, `done`=0, `rd_addr`=0. All internal state is cleared.
- Packet byte sequence:
  - byte 0 = `{4'h5, port_number}`
  - byte 1 = `{5'b0, flags}`
  - bytes 2..N+1 = buffer[0..N-1]
- Data length N uses priority on `flags`: bit2 → 18, else bit1 → 6, else bit0 → 2, else 0. Total packet is 20/8/4/2 bytes.
- Each byte is framed as start bit (0), 8 data bits LSB first, stop bit (1). There is no gap between bytes of one packet.
- FSM states: IDLE, HEADER, FLAGS, DATA, GAP.
  - IDLE → HEADER on `start` && !`busy`.
  - HEADER → FLAGS after byte 0's stop bit.
  - FLAGS → DATA if N>0, else FLAGS → GAP.
  - DATA stays in DATA until data byte N-1's stop bit, then → GAP.
  - GAP → IDLE after `IDLE_BITS`×`CLKS_PER_BIT` cycles.
- `rd_addr` is set to i before data byte i is loaded. The serializer captures `rd_data` at the load of byte i, which is at least 2 cycles after `rd_addr`=i.
- `rd_addr` advances to i+1 during byte i's start bit. After the last byte it stays at N-1 and returns to 0 in IDLE.
- The buffer is read byte by byte with no snapshot. The writer must keep it stable during `busy`, or accept tearing.
- `start` while `busy`=1 is ignored; nothing is queued. `port_number` and `flags` changes mid-packet have no effect.
- Reset mid-packet: `SERIAL_TX` returns to 1 immediately. The receiver discards the fragment on its idle timeout.

## Timing
- `start` accepted at edge k: `busy`=1 and `SERIAL_TX`=0 (start bit of byte 0) from cycle k+1.
- Every bit holds exactly `CLKS_PER_BIT` cycles; a byte lasts 10×`CLKS_PER_BIT`.
- Total busy time T = (N+2)×10×`CLKS_PER_BIT` + `IDLE_BITS`×`CLKS_PER_BIT` cycles.
- `done` pulses in the last cycle of GAP. `busy` falls the following cycle.
- Earliest next accepted `start` is the cycle `busy` reads 0. Back-to-back packets are therefore separated by exactly the gap plus 1 cycle.
- The bit counter in `serial_tx` is `$clog2(CLKS_PER_BIT)` wide and reloads at CLKS_PER_BIT-1. The byte counter is 5 bits, and the gap counter is sized for `IDLE_BITS`×`CLKS_PER_BIT`.

## Structure
- Shared package `psx_link_pkg`:
  - header nibble constant `4'h5`
  - flag bit indices
  - data-length function `flags → {0,2,6,18}`, shared with the receiver side
  - FSM state enum
- Sub-module `serial_tx`:
  - interface: `FIFO_clk`, `reset`, `load`, `data[7:0]`, `ready`, `tx`
  - 8N1 shifter with baud counter
  - `ready` is high in the last cycle of the stop bit, allowing a seamless next load
- The top level holds the framing FSM, address counter and gap timer.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `IDLE_BITS`=2.
- Reset asserted → `SERIAL_TX`=1, `busy`=0, `done`=0, `rd_addr`=0. Releasing reset with `start`=0 keeps all outputs at these values.
- `start` with port 3, flags 000 → decoded bytes 0x53, 0x00; `SERIAL_TX`=0 at k+1; `done` at k+88; `busy`=0 at k+89.
- Port 0, flags 001, buffer {0xA5, 0x3C} → bytes 0x50, 0x01, 0xA5, 0x3C; `rd_addr` visits 0, 1; T=168.
- Flags 110 and flags 100 → both give 20 bytes with `rd_addr` 0..17. Flags bytes are 0x06 and 0x04 respectively. Bench decoder checks every stop bit is 1.
- `start` pulsed mid-packet and in the `done` cycle → ignored. A `start` in the first cycle with `busy`=0 is accepted.
- Reset asserted during data byte 3 → `SERIAL_TX`=1 asynchronously. A new `start` after release yields an intact 8-byte packet.

Source files
------------

// File: rtl/psx_link_pkg.sv
// -----------------------------------------------------------------------------
// psx_link_pkg
// Shared definitions for the PSX controller-state serial link. Used by the
// transmitter (psx_packet_tx) and by the receiver on the emulator board, so the
// framing constants and the flags -> data-length rule live in one place.
//   HEADER_NIBBLE : upper nibble of packet byte 0
//   FLAG_BIT_*    : bit positions inside the 3-bit flags field
//   data_len()    : number of buffer bytes that follow the flags byte
//   tx_state_e    : framing FSM states of the transmitter
// -----------------------------------------------------------------------------
package psx_link_pkg;

  localparam logic [3:0] HEADER_NIBBLE = 4'h5;

  localparam int FLAG_BIT_SHORT = 0;
  localparam int FLAG_BIT_MID   = 1;
  localparam int FLAG_BIT_LONG  = 2;

  localparam logic [4:0] LEN_NONE  = 5'd0;
  localparam logic [4:0] LEN_SHORT = 5'd2;
  localparam logic [4:0] LEN_MID   = 5'd6;
  localparam logic [4:0] LEN_LONG  = 5'd18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FLAGS,
    S_DATA,
    S_GAP
  } tx_state_e;

  // Highest set flag bit wins.
  function automatic logic [4:0] data_len(input logic [2:0] flags);
    if (flags[FLAG_BIT_LONG])       return LEN_LONG;
    else if (flags[FLAG_BIT_MID])   return LEN_MID;
    else if (flags[FLAG_BIT_SHORT]) return LEN_SHORT;
    else                            return LEN_NONE;
  endfunction

endpackage

// File: rtl/psx_packet_tx_serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// 8N1 UART byte shifter with an internal baud counter.
//   FIFO_clk : clock
//   reset    : asynchronous, active-high
//   load     : accept data when ready is high; start bit begins next cycle
//   data     : byte to send, LSB first
//   ready    : high when idle and in the last cycle of a stop bit, so a byte
//              loaded then follows the previous one without any gap
//   tx       : serial line, idle high (driven straight from a flop)
// -----------------------------------------------------------------------------
module serial_tx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       FIFO_clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic [9:0]    r_frame;    // {stop, data[7:0], start}; bit 0 is on the line
  logic [CW-1:0] r_baud_cnt;
  logic [3:0]    r_bit_idx;

  logic w_bit_end;
  logic w_last_bit;

  assign w_bit_end  = (r_baud_cnt == '0);
  assign w_last_bit = (r_bit_idx == 4'd9);
  assign ready      = !r_active || (w_bit_end && w_last_bit);
  assign tx         = r_frame[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      r_active   <= 1'b0;
      r_frame    <= '1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (load && ready) begin
      r_active   <= 1'b1;
      r_frame    <= {1'b1, data, 1'b0};
      r_baud_cnt <= BAUD_RELOAD;
      r_bit_idx  <= '0;
    end else if (r_active) begin
      if (w_bit_end) begin
        if (w_last_bit) begin
          r_active <= 1'b0;
          r_frame  <= '1;
        end else begin
          r_frame    <= {1'b1, r_frame[9:1]};
          r_bit_idx  <= r_bit_idx + 4'd1;
          r_baud_cnt <= BAUD_RELOAD;
        end
      end else begin
        r_baud_cnt <= r_baud_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/psx_packet_tx.sv
// -----------------------------------------------------------------------------
// psx_packet_tx
// Frames a controller-state snapshot as {5,port}, {00000,flags}, N buffer
// bytes and sends it as back-to-back 8N1 bytes, followed by a forced idle gap.
//   FIFO_clk    : clock
//   reset       : asynchronous, active-high
//   start       : request a packet (only honoured while busy is low)
//   port_number : slot address, captured with start
//   flags       : state flags, captured with start; select N = 0/2/6/18
//   rd_addr     : buffer read address (data byte index)
//   rd_data     : buffer read data, one cycle after rd_addr
//   busy        : packet or idle gap in progress
//   done        : one-cycle pulse in the final gap cycle
//   SERIAL_TX   : UART line, idle high
// -----------------------------------------------------------------------------
module psx_packet_tx
  import psx_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int IDLE_BITS    = 16
) (
  input  logic       FIFO_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] port_number,
  input  logic [2:0] flags,
  output logic [4:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       SERIAL_TX
);

  localparam int GAP_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

  tx_state_e     r_state;
  logic [2:0]    r_flags;
  logic [4:0]    r_len;
  logic [4:0]    r_data_cnt;   // data bytes handed to the serializer so far
  logic [4:0]    r_rd_addr;
  logic [GW-1:0] r_gap_cnt;

  tx_state_e     w_state_next;
  logic          w_load;
  logic [7:0]    w_load_data;
  logic          w_data_load;
  logic          w_ready;
  logic          w_done;

  serial_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serial_tx (
    .FIFO_clk(FIFO_clk),
    .reset   (reset),
    .load    (w_load),
    .data    (w_load_data),
    .ready   (w_ready),
    .tx      (SERIAL_TX)
  );

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_data_load  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Byte 0 is built from the live inputs so its start bit appears the
        // cycle right after start is accepted.
        if (start) begin
          w_load       = 1'b1;
          w_load_data  = {HEADER_NIBBLE, port_number};
          w_state_next = S_HEADER;
        end
      end
      S_HEADER: begin
        if (w_ready) begin
          w_load       = 1'b1;
          w_load_data  = {5'b0, r_flags};
          w_state_next = S_FLAGS;
        end
      end
      S_FLAGS: begin
        if (w_ready) begin
          if (r_len != LEN_NONE) begin
            w_load       = 1'b1;
            w_load_data  = rd_data;
            w_data_load  = 1'b1;
            w_state_next = S_DATA;
          end else begin
            w_state_next = S_GAP;
          end
        end
      end
      S_DATA: begin
        if (w_ready) begin
          if (r_data_cnt == r_len) begin
            w_state_next = S_GAP;
          end else begin
            w_load       = 1'b1;
            w_load_data  = rd_data;
            w_data_load  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Captured packet parameters, data byte counter and read address.
  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      r_flags    <= '0;
      r_len      <= '0;
      r_data_cnt <= '0;
      r_rd_addr  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_flags    <= flags;
        r_len      <= data_len(flags);
        r_data_cnt <= '0;
        r_rd_addr  <= '0;
      end
      if (w_data_load) begin
        r_data_cnt <= r_data_cnt + 5'd1;
        // Point at the next byte during this byte's start bit; the buffer
        // then has the whole byte time to present it. Hold at N-1 at the end.
        if ((r_data_cnt + 5'd1) < r_len) r_rd_addr <= r_rd_addr + 5'd1;
      end
      if (w_done) r_rd_addr <= '0;
    end
  end

  // Gap timer: loaded on entry to GAP, so GAP lasts exactly GAP_CYCLES.
  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt <= '0;
    end else if (w_state_next == S_GAP && r_state != S_GAP) begin
      r_gap_cnt <= GAP_RELOAD;
    end else if (r_state == S_GAP && r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = w_done;
  assign rd_addr = r_rd_addr;

endmodule
